// File: rtl/cbus_mem_responder.sv
// Memory-side burst responder for the simplified AXI cache bus: accepts one burst
// request, waits LATENCY cycles, then serves one read or write beat per cycle from a 64-bit RAM.
package cbus_pkg;
  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;
  localparam logic [1:0] BURST_RSVD  = 2'd3;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [7:0]  len;
    logic [1:0]  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;
endpackage

// state | meaning
// IDLE  | waiting for creq.valid; also holds during the final beat so it is not re-accepted
// WAIT  | counting down the access latency
// BURST | registering one beat per edge until beat counter == len
module cbus_mem_responder
  import cbus_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 4096,
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
  parameter int unsigned LATENCY   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp
);

  localparam int unsigned IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [63:0] MEM_BYTES = 64'(MEM_WORDS) << 3;
  localparam logic [15:0] LAT_INIT  = 16'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_e;

  state_e state_q, state_d;

  logic [63:0] addr_q, addr_d;
  logic [63:0] beat_addr_q, beat_addr_d;
  logic [2:0]  size_q, size_d;
  logic [7:0]  len_q, len_d;
  logic [1:0]  burst_q, burst_d;
  logic        wr_q, wr_d;
  logic [7:0]  beat_q, beat_d;
  logic [15:0] lat_q, lat_d;
  logic        ready_q, ready_d;
  logic        last_q, last_d;
  logic [63:0] data_q, data_d;

  logic [63:0] mem_q [MEM_WORDS];

  function automatic logic in_range(input logic [63:0] a);
    return (a >= BASE_ADDR) && ((a - BASE_ADDR) < MEM_BYTES);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [63:0] a);
    return IDX_W'((a - BASE_ADDR) >> 3);
  endfunction

  function automatic logic [63:0] next_addr(input logic [63:0] a, input logic [2:0] size,
                                            input logic [7:0] len, input logic [1:0] burst);
    logic [63:0] step;
    logic [63:0] mask;
    logic [63:0] nxt;
    step = 64'd1 << size;
    mask = ((64'(len) + 64'd1) << size) - 64'd1;
    case (burst)
      BURST_FIXED: nxt = a;
      BURST_WRAP:  nxt = (a & ~mask) | ((a + step) & mask);
      default:     nxt = a + step;
    endcase
    return nxt;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // A dropped valid in WAIT or BURST is a requester violation and aborts the burst.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (creq.valid && !ready_q) state_d = (LATENCY <= 1) ? S_BURST : S_WAIT;
      S_WAIT:  if (!creq.valid) state_d = S_IDLE;
               else if (lat_q <= 16'd1) state_d = S_BURST;
      S_BURST: if (!creq.valid || beat_q == len_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d      = addr_q;
    beat_addr_d = beat_addr_q;
    size_d      = size_q;
    len_d       = len_q;
    burst_d     = burst_q;
    wr_d        = wr_q;
    beat_d      = beat_q;
    lat_d       = lat_q;
    ready_d     = 1'b0;
    last_d      = 1'b0;
    data_d      = 64'd0;
    case (state_q)
      S_IDLE: begin
        if (creq.valid && !ready_q) begin
          addr_d  = creq.addr;
          size_d  = creq.size;
          len_d   = creq.len;
          burst_d = creq.burst;
          wr_d    = creq.is_write;
          beat_d  = 8'd0;
          lat_d   = LAT_INIT;
        end
      end
      S_WAIT: begin
        if (creq.valid) lat_d = lat_q - 16'd1;
      end
      S_BURST: begin
        if (creq.valid) begin
          ready_d     = 1'b1;
          last_d      = (beat_q == len_q);
          beat_addr_d = addr_q;
          if (!wr_q && in_range(addr_q)) data_d = mem_q[word_idx(addr_q)];
          addr_d      = next_addr(addr_q, size_q, len_q, burst_q);
          beat_d      = beat_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q      <= '0;
      beat_addr_q <= '0;
      size_q      <= '0;
      len_q       <= '0;
      burst_q     <= '0;
      wr_q        <= 1'b0;
      beat_q      <= '0;
      lat_q       <= '0;
      ready_q     <= 1'b0;
      last_q      <= 1'b0;
      data_q      <= '0;
    end else begin
      addr_q      <= addr_d;
      beat_addr_q <= beat_addr_d;
      size_q      <= size_d;
      len_q       <= len_d;
      burst_q     <= burst_d;
      wr_q        <= wr_d;
      beat_q      <= beat_d;
      lat_q       <= lat_d;
      ready_q     <= ready_d;
      last_q      <= last_d;
      data_q      <= data_d;
    end
  end

  // Write data belongs to the beat currently shown with ready; it commits at the edge ending it.
  always_ff @(posedge clk) begin
    if (!reset && ready_q && wr_q && in_range(beat_addr_q)) begin
      for (int i = 0; i < 8; i++) begin
        if (creq.strobe[i]) mem_q[word_idx(beat_addr_q)][8*i +: 8] <= creq.data[8*i +: 8];
      end
    end
  end

  assign cresp = '{ready: ready_q, last: last_q, data: data_q};

endmodule

// File: tb/tb_cbus_mem_responder.sv
// Scoreboard bench for cbus_mem_responder: directed scenarios plus randomized bursts,
// checked against a word-array reference model of the memory.
module tb_cbus_mem_responder;
  import cbus_pkg::*;

  localparam int unsigned LAT   = 2;
  localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
  localparam int          WORDS = 4096;

  logic       clk = 1'b0;
  logic       reset;
  cbus_req_t  creq;
  cbus_resp_t cresp;

  cbus_mem_responder #(.MEM_WORDS(WORDS), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .creq(creq), .cresp(cresp)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic        last;
    logic [63:0] data;
    longint      cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] ref_mem [WORDS];
  logic [63:0] bdata [256];
  logic [7:0]  bstrb [256];

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic bit ref_in(input logic [63:0] a);
    return (a >= BASE) && (a < BASE + 64'(WORDS) * 8);
  endfunction

  function automatic int ref_idx(input logic [63:0] a);
    return int'((a - BASE) / 8);
  endfunction

  // Next beat address from the burst rules, using modulo arithmetic for WRAP.
  function automatic logic [63:0] ref_next(input logic [63:0] a, input int size, input int len, input int burst);
    logic [63:0] step, blk, lo;
    step = 64'd1 << size;
    if (burst == 0) return a;
    if (burst == 2) begin
      blk = 64'(len + 1) * step;
      lo  = a - (a % blk);
      return lo + ((a - lo + step) % blk);
    end
    return a + step;
  endfunction

  // Monitor: every beat pops one expectation; idle cycles must show zero outputs.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (cresp.ready === 1'b1) begin
        if (exp_q.size() == 0) check(1'b0, "unexpected_beat", cresp.data, 64'd0);
        else begin
          e = exp_q.pop_front();
          check(cresp.data === e.data, "beat_data", cresp.data, e.data);
          check(cresp.last === e.last, "beat_last", 64'(cresp.last), 64'(e.last));
          check(cyc == e.cyc, "beat_cycle", 64'(cyc), 64'(e.cyc));
        end
      end else begin
        check(cresp.ready === 1'b0 && cresp.last === 1'b0 && cresp.data === 64'd0, "idle_zero",
              {cresp.data[61:0], cresp.last, cresp.ready}, 64'd0);
      end
    end
  end

  task automatic fill_rand(input bit full_strobe);
    for (int i = 0; i < 256; i++) begin
      bdata[i] = {$urandom, $urandom};
      bstrb[i] = full_strobe ? 8'hff : 8'($urandom);
    end
  endtask

  // Call #1 after a posedge. abort_beat >= 0 asserts reset while that beat is shown.
  task automatic do_txn(input bit wr, input int size, input logic [63:0] addr, input int len,
                        input int burst, input int abort_beat);
    logic [63:0] a;
    longint      k;
    int          n_last;
    exp_t        e;
    a = addr;
    k = cyc;
    n_last = (abort_beat >= 0) ? abort_beat : len;
    for (int n = 0; n <= n_last; n++) begin
      e.last = (n == len);
      e.data = (wr || !ref_in(a)) ? 64'd0 : ref_mem[ref_idx(a)];
      e.cyc  = k + 1 + LAT + n;
      exp_q.push_back(e);
      if (wr && n != abort_beat && ref_in(a)) begin
        for (int b = 0; b < 8; b++)
          if (bstrb[n][b]) ref_mem[ref_idx(a)][8*b +: 8] = bdata[n][8*b +: 8];
      end
      a = ref_next(a, size, len, burst);
    end
    creq.valid    = 1'b1;
    creq.is_write = wr;
    creq.size     = 3'(size);
    creq.addr     = addr;
    creq.len      = 8'(len);
    creq.burst    = 2'(burst);
    creq.data     = bdata[0];
    creq.strobe   = bstrb[0];
    for (int n = 0; n <= n_last; n++) begin
      int t;
      t = 0;
      @(negedge clk);
      while (cresp.ready !== 1'b1 && t < 300) begin
        @(negedge clk);
        t++;
      end
      if (cresp.ready !== 1'b1) begin
        check(1'b0, "beat_timeout", 64'(n), 64'(len));
        exp_q.delete();
        break;
      end
      if (n == abort_beat) begin
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        break;
      end
      @(posedge clk);
      #1;
      if (n < len) begin
        creq.data   = bdata[n + 1];
        creq.strobe = bstrb[n + 1];
      end
    end
    creq.valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [63:0] addr, step;
    int wr, size, len, burst;
    reset = 1'b1;
    creq  = '0;
    repeat (3) @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Preload the whole RAM with random words (256-beat bursts).
    for (int blk = 0; blk < WORDS / 256; blk++) begin
      fill_rand(1'b1);
      do_txn(1, 3, BASE + 64'(blk) * 2048, 255, 1, -1);
    end

    // Single write then read.
    bdata[0] = 64'hDEAD_BEEF_CAFE_F00D;
    bstrb[0] = 8'hff;
    do_txn(1, 3, 64'h8000_0008, 0, 1, -1);
    do_txn(0, 3, 64'h8000_0008, 0, 1, -1);

    // INCR 16-beat write of i, then read back.
    for (int i = 0; i < 16; i++) begin
      bdata[i] = 64'(i);
      bstrb[i] = 8'hff;
    end
    do_txn(1, 3, BASE, 15, 1, -1);
    do_txn(0, 3, BASE, 15, 1, -1);

    // WRAP over words holding their own addresses.
    for (int i = 0; i < 4; i++) begin
      bdata[i] = BASE + 64'(i) * 8;
      bstrb[i] = 8'hff;
    end
    do_txn(1, 3, BASE, 3, 1, -1);
    do_txn(0, 3, 64'h8000_0010, 3, 2, -1);

    // Partial strobe.
    bdata[0] = 64'd0;
    bstrb[0] = 8'hff;
    do_txn(1, 3, BASE, 0, 1, -1);
    bdata[0] = 64'h0000_0000_0011_0000;
    bstrb[0] = 8'b0000_0100;
    do_txn(1, 0, 64'h8000_0002, 0, 1, -1);
    do_txn(0, 3, BASE, 0, 1, -1);

    // Out of range read and write.
    do_txn(0, 3, 64'h0, 3, 1, -1);
    fill_rand(1'b1);
    do_txn(1, 3, 64'h0, 0, 1, -1);
    do_txn(0, 3, BASE, 0, 1, -1);

    // Reset during beat 3 of an 8-beat write, then read back.
    for (int i = 0; i < 8; i++) begin
      bdata[i] = 64'hA0 + 64'(i);
      bstrb[i] = 8'hff;
    end
    do_txn(1, 3, BASE, 7, 1, 3);
    do_txn(0, 3, BASE, 7, 1, -1);

    // Randomized bursts.
    for (int r = 0; r < 60; r++) begin
      wr    = int'($urandom_range(0, 1));
      size  = int'($urandom_range(0, 3));
      burst = int'($urandom_range(0, 3));
      if (burst == 2) len = (2 << $urandom_range(0, 3)) - 1;
      else            len = int'($urandom_range(0, 15));
      step = 64'd1 << size;
      if ($urandom_range(0, 7) == 0) addr = 64'($urandom_range(0, 4095)) << 3;
      else                           addr = BASE + (64'($urandom_range(0, 4095)) << 3);
      addr = addr + (64'($urandom_range(0, 7)) & ~(step - 64'd1));
      fill_rand(1'b0);
      do_txn(wr[0], size, addr, len, burst, -1);
    end

    repeat (5) @(posedge clk);
    #1;
    check(exp_q.size() == 0, "queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
